imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have exactly one clock, clk; reset is synchronous and active-high, port reset.
REQ-002 The block SHALL provide parameter DATA_W, default 24, instruction word width.
REQ-003 The block SHALL provide parameter ADDR_W, default 24, instruction memory address width.
REQ-004 The block SHALL provide parameter DEPTH, default 128, number of instruction memory words.
REQ-005 The block SHALL have these ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  single-cycle request to begin a load.
- word_count  in  8  number of words to load.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  incoming program byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction memory write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write word.
- busy  out  1  load in progress; processor held.
- done  out  1  one-cycle pulse when a load completes.
- checksum  out  8  XOR of all bytes accepted in the current or last load.

Function
REQ-006 The block SHALL implement states IDLE, B0, B1, B2, WRITE and FIN.
REQ-007 In IDLE, start=1 SHALL clear the word address to 0 and checksum to 0x00, latch the effective count, and move to B0 the next cycle.
REQ-008 The effective count SHALL be min(word_count, DEPTH); with defaults, word_count=200 loads 128 words.
REQ-009 An effective count of 0 SHALL go from IDLE directly to FIN with no wr_en.
REQ-010 byte_ready SHALL be 1 only in B0, B1 and B2; a byte is accepted on a cycle with byte_valid=1 and byte_ready=1.
REQ-011 Byte order SHALL be MSB first:
- B0 byte goes to bits 23:16.
- B1 byte goes to bits 15:8.
- B2 byte goes to bits 7:0.
- Each accepted byte advances the state by one; B2 advances to WRITE.
REQ-012 With byte_valid=0, the block SHALL stay in its current B state indefinitely with the partial word retained.
REQ-013 In WRITE, wr_en SHALL be 1 for exactly one cycle, with wr_addr equal to the current word address and wr_data equal to the assembled word.
- wr_en is therefore asserted the cycle after the third byte is accepted.
REQ-014 After WRITE, the block SHALL increment the word address and go to B0, or go to FIN if this was the last word.
- The address never exceeds DEPTH-1 and never wraps.
REQ-015 In FIN, done SHALL be 1 for one cycle and the state SHALL return to IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE.
REQ-017 start SHALL be ignored while busy=1.
REQ-018 checksum SHALL XOR in each accepted byte on the acceptance cycle.
- It holds its value after done until the next start.
REQ-019 wr_en, byte_ready, busy and done SHALL be registered outputs with no combinational path from inputs.
REQ-020 wr_addr SHALL hold its last value when wr_en=0; wr_data SHALL hold the last assembled value.

Reset
REQ-021 reset=1 SHALL force, on the next clk edge:
- state to IDLE.
- wr_en, byte_ready, busy and done to 0.
- wr_addr, wr_data, checksum and the internal byte counters to 0.
REQ-022 Reset during a load SHALL abort it: no further wr_en and no done pulse.
- Words already written remain in memory.
REQ-023 reset SHALL take priority over start and byte_valid in the same cycle.

Structure
REQ-024 DATA_W, ADDR_W, DEPTH and the state encoding SHALL reside in the shared processor package used by the instruction memory and fetch logic.
REQ-025 The byte-to-word assembler (shift register plus byte index) SHALL be one sub-module, imem_word_pack; the FSM, address counter and checksum stay in the top.

Verification
REQ-026 Single-word load: start with word_count=1, then bytes 0x31, 0x00, 0xFF back-to-back.
- Required: one wr_en with wr_addr=0 and wr_data=0x3100FF.
- Required: done the following cycle and checksum=0xCE.
REQ-027 Two-word load with gaps: word_count=2, bytes 0x31,0x20,0x00 then 0x48,0x28,0x00, byte_valid low 3 cycles between bytes.
- Required: writes (0, 0x312000) then (1, 0x482800).
- Required: no extra wr_en and byte_ready held through the gaps.
REQ-028 Clamp: word_count=200 with a continuous byte stream.
- Required: exactly 128 wr_en pulses, last at wr_addr=127, then done.
- Required: byte_ready=0 after byte 384.
REQ-029 Zero count: start with word_count=0.
- Required: busy for one cycle, done pulse, no wr_en, checksum=0x00.
REQ-030 Abort and restart: word_count=4, reset asserted after the 5th byte.
- Required: one write at address 0, then all outputs 0.
- Required: a subsequent start with word_count=1 writes at address 0.
REQ-031 Start during load: start pulsed while in B1.
- Required: no effect; address and checksum continue unchanged.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared processor constants and loader state encoding, used by the
// instruction memory, the fetch logic and the program loader.
package imem_loader_pkg;

  localparam int IMEM_DATA_W = 24;
  localparam int IMEM_ADDR_W = 24;
  localparam int IMEM_DEPTH  = 128;

  typedef enum logic [2:0] {
    IDLE,
    B0,
    B1,
    B2,
    WRITE,
    FIN
  } ld_state_t;

  function automatic logic is_byte_state(input ld_state_t s);
    return s inside {B0, B1, B2};
  endfunction

endpackage

// File: rtl/imem_word_pack.sv
// Byte-to-word assembler: MSB-first shift register plus byte index.
// word_nx is the word as it will stand once the current byte is taken.
module imem_word_pack #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_data,
  output logic [DATA_W-1:0] word_nx,
  output logic              word_done
);

  logic [DATA_W-1:0] word;
  logic [1:0]        idx;

  assign word_nx   = {word[DATA_W-9:0], byte_data};
  assign word_done = accept && (idx == 2'd2);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word <= '0;
      idx  <= '0;
    end else if (accept) begin
      word <= word_nx;
      idx  <= word_done ? 2'd0 : idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: packs a byte stream into words, writes them
// from address 0 upward and keeps a running XOR checksum of the bytes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W,
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        checksum
);

  ld_state_t         state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        cnt, eff_count;
  logic              accept, load, last_word, word_done;
  logic [DATA_W-1:0] word_nx;

  assign accept    = byte_valid & byte_ready;
  assign load      = (state == IDLE) & start;
  assign eff_count = (32'(word_count) > DEPTH) ? 8'(DEPTH) : word_count;
  assign last_word = (addr + ADDR_W'(1)) == ADDR_W'(cnt);

  imem_word_pack #(.DATA_W(DATA_W)) u_pack (
    .clk       (clk),
    .reset     (reset),
    .clear     (load),
    .accept    (accept),
    .byte_data (byte_data),
    .word_nx   (word_nx),
    .word_done (word_done)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (eff_count == 8'd0) ? FIN : B0;
      B0:      if (accept) state_nx = B1;
      B1:      if (accept) state_nx = B2;
      B2:      if (word_done) state_nx = WRITE;
      WRITE:   state_nx = last_word ? FIN : B0;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Flag outputs are decoded from the next state so they are plain flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      checksum   <= 8'h00;
      addr       <= '0;
      cnt        <= 8'd0;
    end else begin
      state      <= state_nx;
      byte_ready <= is_byte_state(state_nx);
      busy       <= (state_nx != IDLE);
      done       <= (state_nx == FIN);
      wr_en      <= (state_nx == WRITE);
      if (state_nx == WRITE) begin
        wr_addr <= addr;
        wr_data <= word_nx;
      end
      if (load) begin
        addr     <= '0;
        cnt      <= eff_count;
        checksum <= 8'h00;
      end else begin
        if (accept) checksum <= checksum ^ byte_data;
        if (state == WRITE && !last_word) addr <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus random loads
// checked against a byte-list model of the expected writes and checksum.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, byte_valid;
  logic [7:0]  word_count, byte_data;
  logic        byte_ready, wr_en, busy, done;
  logic [23:0] wr_addr, wr_data;
  logic [7:0]  checksum;

  int total = 0, bad = 0, done_cnt = 0;
  bit stall;
  logic [47:0] wq[$];
  logic [7:0]  sent[$];

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) wq.push_back({wr_addr, wr_data});
    if (done) done_cnt++;
  end

  // Model: word i is bytes 3i..3i+2 MSB first at address i; checksum is XOR of all bytes.
  function automatic int eff(input int wc);
    return (wc > 128) ? 128 : wc;
  endfunction

  function automatic logic [7:0] xsum();
    logic [7:0] x = 8'h00;
    foreach (sent[i]) x ^= sent[i];
    return x;
  endfunction

  function automatic logic [47:0] exp_wr(input int i);
    return {24'(i), sent[3*i], sent[3*i+1], sent[3*i+2]};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) stall = 1'b1;
    else begin
      sent.push_back(b);
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] wc);
    sent.delete();
    wq.delete();
    stall      = 1'b0;
    word_count = wc;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int t = 0;
    while (busy && t < 2000) begin @(negedge clk); t++; end
    ok = !busy;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; byte_valid = 1'b1; word_count = 8'd5; byte_data = 8'hAA;
    repeat (2) @(negedge clk);
    total++;
    if ({wr_en, byte_ready, busy, done} !== 4'b0 || wr_addr !== 24'd0 || wr_data !== 24'd0 || checksum !== 8'h00) begin
      bad++;
      $display("FAIL reset_state got en/rdy/busy/done=%b addr=%0h data=%0h sum=%0h want all 0",
               {wr_en, byte_ready, busy, done}, wr_addr, wr_data, checksum);
    end
    reset = 1'b0; start = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_start_ignored busy=%b want 0", busy); end
  endtask

  task automatic test_single();
    bit ok;
    do_start(8'd1);
    send_byte(8'h31); send_byte(8'h00); send_byte(8'hFF);
    total++;
    if (wr_en !== 1'b1 || wr_addr !== 24'd0 || wr_data !== 24'h3100FF) begin
      bad++;
      $display("FAIL single_write en=%b addr=%0h data=%0h want 1/0/3100ff", wr_en, wr_addr, wr_data);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || wr_en !== 1'b0 || checksum !== 8'hCE) begin
      bad++;
      $display("FAIL single_done done=%b en=%b sum=%0h want 1/0/ce", done, wr_en, checksum);
    end
    wait_idle(ok);
    total++;
    if (!ok || stall || wq.size() != 1) begin
      bad++; $display("FAIL single_count ok=%b stall=%b writes=%0d want 1/0/1", ok, stall, wq.size());
    end
  endtask

  task automatic test_gaps();
    logic [7:0] bytes [6] = '{8'h31, 8'h20, 8'h00, 8'h48, 8'h28, 8'h00};
    bit ok;
    do_start(8'd2);
    for (int k = 0; k < 6; k++) begin
      send_byte(bytes[k]);
      if (k < 5) begin
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          if (k % 3 != 2) begin
            total++;
            if (byte_ready !== 1'b1) begin
              bad++; $display("FAIL gap_ready byte=%0d gap=%0d rdy=%b want 1", k, g, byte_ready);
            end
          end
        end
      end
    end
    wait_idle(ok);
    total++;
    if (!ok || stall || wq.size() != 2) begin
      bad++; $display("FAIL gap_count ok=%b stall=%b writes=%0d want 1/0/2", ok, stall, wq.size());
    end else begin
      total++;
      if (wq[0] !== {24'd0, 24'h312000} || wq[1] !== {24'd1, 24'h482800}) begin
        bad++; $display("FAIL gap_words got %0h %0h want 000000312000 000001482800", wq[0], wq[1]);
      end
    end
  endtask

  task automatic test_clamp();
    int prev = done_cnt;
    int errs = 0;
    bit ok;
    do_start(8'd200);
    for (int k = 0; k < 384; k++) send_byte(8'($urandom));
    while (busy && errs < 10) begin
      if (byte_ready !== 1'b0) errs++;
      @(negedge clk);
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL clamp_ready_after_384 rdy_high_cycles=%0d want 0", errs); end
    wait_idle(ok);
    total++;
    if (!ok || stall || wq.size() != eff(200) || done_cnt != prev + 1) begin
      bad++;
      $display("FAIL clamp_count ok=%b stall=%b writes=%0d dones=%0d want 1/0/128/1", ok, stall, wq.size(), done_cnt - prev);
    end else begin
      errs = 0;
      for (int i = 0; i < 128; i++) if (wq[i] !== exp_wr(i)) errs++;
      total++;
      if (errs != 0 || wq[127][47:24] !== 24'd127) begin
        bad++; $display("FAIL clamp_words bad_words=%0d last_addr=%0d want 0/127", errs, wq[127][47:24]);
      end
    end
    total++;
    if (checksum !== xsum()) begin bad++; $display("FAIL clamp_sum got=%0h want=%0h", checksum, xsum()); end
  endtask

  task automatic test_zero();
    do_start(8'd0);
    total++;
    if (busy !== 1'b1 || done !== 1'b1 || byte_ready !== 1'b0 || checksum !== 8'h00) begin
      bad++; $display("FAIL zero_fin busy=%b done=%b rdy=%b sum=%0h want 1/1/0/00", busy, done, byte_ready, checksum);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || wq.size() != 0 || checksum !== 8'h00) begin
      bad++; $display("FAIL zero_idle busy=%b done=%b writes=%0d sum=%0h want 0/0/0/00", busy, done, wq.size(), checksum);
    end
  endtask

  task automatic test_abort();
    int prev;
    bit ok;
    do_start(8'd4);
    for (int k = 0; k < 5; k++) send_byte(8'($urandom));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({wr_en, byte_ready, busy, done} !== 4'b0 || wr_addr !== 24'd0 || wr_data !== 24'd0 || checksum !== 8'h00) begin
      bad++;
      $display("FAIL abort_outputs en/rdy/busy/done=%b addr=%0h data=%0h sum=%0h want all 0",
               {wr_en, byte_ready, busy, done}, wr_addr, wr_data, checksum);
    end
    total++;
    if (wq.size() != 1 || wq[0] !== exp_wr(0)) begin
      bad++; $display("FAIL abort_first_write writes=%0d want 1 at addr 0", wq.size());
    end
    prev = done_cnt;
    repeat (10) @(negedge clk);
    total++;
    if (done_cnt != prev || wq.size() != 1 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_quiet dones=%0d writes=%0d busy=%b want 0/1/0", done_cnt - prev, wq.size(), busy);
    end
    do_start(8'd1);
    for (int k = 0; k < 3; k++) send_byte(8'($urandom));
    wait_idle(ok);
    total++;
    if (!ok || stall || wq.size() != 1 || wq[0] !== exp_wr(0)) begin
      bad++; $display("FAIL abort_restart ok=%b writes=%0d got=%0h want=%0h", ok, wq.size(), wq.size() ? wq[0] : 48'h0, exp_wr(0));
    end
  endtask

  task automatic test_start_during_load();
    bit ok;
    do_start(8'd2);
    send_byte(8'h5A);
    word_count = 8'd7;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || byte_ready !== 1'b1 || checksum !== 8'h5A) begin
      bad++; $display("FAIL midstart_state busy=%b rdy=%b sum=%0h want 1/1/5a", busy, byte_ready, checksum);
    end
    for (int k = 0; k < 5; k++) send_byte(8'($urandom));
    wait_idle(ok);
    total++;
    if (!ok || stall || wq.size() != 2) begin
      bad++; $display("FAIL midstart_count ok=%b stall=%b writes=%0d want 1/0/2", ok, stall, wq.size());
    end else begin
      total++;
      if (wq[0] !== exp_wr(0) || wq[1] !== exp_wr(1) || checksum !== xsum()) begin
        bad++; $display("FAIL midstart_words got %0h %0h sum=%0h want %0h %0h sum=%0h",
                        wq[0], wq[1], checksum, exp_wr(0), exp_wr(1), xsum());
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int wc = int'($urandom_range(1, 6));
      int prev = done_cnt;
      int errs = 0;
      bit ok;
      do_start(8'(wc));
      for (int k = 0; k < 3 * wc; k++) begin
        send_byte(8'($urandom));
        repeat (int'($urandom_range(0, 2))) @(negedge clk);
      end
      wait_idle(ok);
      total++;
      if (!ok || stall || wq.size() != eff(wc) || done_cnt != prev + 1) begin
        bad++;
        $display("FAIL rand_count run=%0d ok=%b writes=%0d dones=%0d want %0d/1", r, ok, wq.size(), done_cnt - prev, wc);
      end else begin
        for (int i = 0; i < wc; i++) if (wq[i] !== exp_wr(i)) errs++;
        total++;
        if (errs != 0 || checksum !== xsum()) begin
          bad++; $display("FAIL rand_words run=%0d bad_words=%0d sum=%0h want 0/%0h", r, errs, checksum, xsum());
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; word_count = 8'd0; byte_data = 8'd0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_gaps();
    test_clamp();
    test_zero();
    test_abort();
    test_start_during_load();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
